// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core has priority, debug port is guaranteed
// a grant after STARVE_MAX consecutive waiting cycles.
module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_we,
    input  logic [31:0] m_rdata,

    output logic        starved
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             c_rvalid_q, c_rvalid_d;
    logic             d_rvalid_q, d_rvalid_d;
    logic [31:0]      c_rdata_q, c_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic             at_max;

    assign at_max = (starve_cnt_q == CNT_MAX);

    // Grants are held low during reset so no memory write can slip through.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (at_max && d_req) begin
                d_gnt = 1'b1;
            end else if (c_req) begin
                c_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    assign m_addr  = d_gnt ? d_addr  : c_addr;
    assign m_wdata = d_gnt ? d_wdata : c_wdata;
    assign m_we    = (c_gnt & c_we) | (d_gnt & d_we);
    assign starved = at_max & d_req;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        c_rvalid_d   = c_gnt & ~c_we;
        d_rvalid_d   = d_gnt & ~d_we;
        c_rdata_d    = c_rdata_q;
        d_rdata_d    = d_rdata_q;

        if (!d_req || d_gnt) begin
            starve_cnt_d = '0;
        end else if (!at_max) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        if (c_rvalid_d) begin
            c_rdata_d = m_rdata;
        end
        if (d_rvalid_d) begin
            d_rdata_d = m_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            c_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            c_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            c_rvalid_q   <= c_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            c_rdata_q    <= c_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected read data is queued per port when
// a read grant is expected and checked by a monitor when rvalid appears.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic        c_gnt, c_rvalid;
    logic [31:0] c_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_we;
    logic        starved;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] c_exp_q [$];
    logic [31:0] d_exp_q [$];

    logic [31:0] mem [1024];

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata),
        .starved(starved)
    );

    assign m_rdata = mem[m_addr[11:2]];
    always @(posedge clk) begin
        if (m_we) mem[m_addr[11:2]] <= m_wdata;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every rvalid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (c_rvalid === 1'b1) begin
            if (c_exp_q.size() == 0) check("c_rvalid_unexpected", 32'd1, 32'd0);
            else check("c_rdata", c_rdata, c_exp_q.pop_front());
        end
        if (d_rvalid === 1'b1) begin
            if (d_exp_q.size() == 0) check("d_rvalid_unexpected", 32'd1, 32'd0);
            else check("d_rdata", d_rdata, d_exp_q.pop_front());
        end
    end

    task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                        input logic ecg, input logic edg, input logic est, input logic [31:0] erd);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        @(negedge clk);
        check("c_gnt", 32'(c_gnt), 32'(ecg));
        check("d_gnt", 32'(d_gnt), 32'(edg));
        check("starved", 32'(starved), 32'(est));
        check("m_we", 32'(m_we), 32'((ecg & cw) | (edg & dw)));
        if (ecg && !cw) c_exp_q.push_back(erd);
        if (edg && !dw) d_exp_q.push_back(erd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Reset with both ports requesting writes.
        c_req = 1; c_we = 1; c_addr = 32'h100; c_wdata = 32'h1111_1111;
        d_req = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'h2222_2222;
        @(negedge clk);
        check("rst_c_gnt", 32'(c_gnt), 32'd0);
        check("rst_d_gnt", 32'(d_gnt), 32'd0);
        check("rst_m_we", 32'(m_we), 32'd0);
        check("rst_c_rvalid", 32'(c_rvalid), 32'd0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst_starved", 32'(starved), 32'd0);
        check("rst_c_rdata", c_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 1, 32'h100, 32'h1111_1111, 1, 1, 32'h104, 32'h2222_2222, 1, 0, 0, 32'h0);

        // Core write then read.
        step(1, 1, 32'h40, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
        step(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'hDEAD_BEEF);
        idle();

        // Contention: four core grants, then a forced debug grant.
        for (int i = 0; i < 5; i++)
            step(1, 0, 32'h40, 32'h0, 1, 0, 32'h0, 32'h0, i < 4, i == 4, i == 4,
                 (i < 4) ? 32'hDEAD_BEEF : 32'h0);
        idle();

        // Debug-only traffic.
        step(0, 0, 32'h0, 32'h0, 1, 1, 32'h0, 32'h1, 0, 1, 0, 32'h0);
        step(0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 0, 1, 0, 32'h1);
        idle();

        // Read-after-write across ports.
        step(1, 1, 32'h8, 32'h55, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
        step(0, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0, 0, 1, 0, 32'h55);
        idle();

        // Write during reset was suppressed; release-cycle core write landed.
        step(1, 0, 32'h104, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
        step(1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h1111_1111);

        // Dropping d_req restarts the starvation count.
        for (int i = 0; i < 2; i++)
            step(1, 0, 32'h8, 32'h0, 1, 0, 32'h40, 32'h0, 1, 0, 0, 32'h55);
        step(1, 0, 32'h8, 32'h0, 0, 0, 32'h40, 32'h0, 1, 0, 0, 32'h55);
        for (int i = 0; i < 5; i++)
            step(1, 0, 32'h8, 32'h0, 1, 0, 32'h40, 32'h0, i < 4, i == 4, i == 4,
                 (i < 4) ? 32'h55 : 32'hDEAD_BEEF);
        idle();

        // Read then write same address, then read back.
        step(1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h55);
        step(1, 1, 32'h8, 32'h66, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
        step(1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h66);
        idle();
        check("c_rdata_hold", c_rdata, 32'h66);

        // Reset lands before the edge that would capture a granted read.
        c_req = 1; c_we = 0; c_addr = 32'h40;
        d_req = 0; d_we = 0;
        @(negedge clk);
        check("mid_c_gnt", 32'(c_gnt), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_c_gnt_rst", 32'(c_gnt), 32'd0);
        @(posedge clk);
        #1;
        check("mid_c_rvalid", 32'(c_rvalid), 32'd0);
        check("mid_c_rdata", c_rdata, 32'd0);
        rst_n = 1'b1;
        idle();
        idle();

        check("c_queue_drained", 32'(c_exp_q.size()), 32'd0);
        check("d_queue_drained", 32'(d_exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the pipeline's load/store stage (core port) and the debug/loader port used by the testbench and program-load logic. It selects one requester per cycle, drives the memory's address, write-data and write-enable, and returns registered read data with a one-cycle valid pulse. The core port normally has priority, and a starvation counter guarantees the debug port forward progress. It sits between the MEM stage / debug interface and the data memory.

## Interface
- `STARVE_MAX`, 4: max consecutive cycles the debug port may wait while requesting; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `c_req`  in  1  core request valid.
- `c_we`  in  1  core write (1) / read (0).
- `c_addr`  in  32  core byte address.
- `c_wdata`  in  32  core write data.
- `c_gnt`  out  1  core request accepted this cycle (combinational).
- `c_rvalid`  out  1  core read data valid (registered pulse).
- `c_rdata`  out  32  core read data (registered).
- `d_req`, `d_we`, `d_addr`, `d_wdata`  in  1/1/32/32  debug port request; same meaning as the core fields.
- `d_gnt`, `d_rvalid`, `d_rdata`  out  1/1/32  debug port response; same meaning as the core fields.
- `m_addr`  out  32  memory byte address (word index is `m_addr[11:2]`).
- `m_wdata`  out  32  memory write data.
- `m_we`  out  1  memory write enable; the write commits at the next rising edge.
- `m_rdata`  in  32  memory read data, combinational from `m_addr`.
- `starved`  out  1  debug port is currently being forced (status).

## Operation
- Transfer rule: a request transfers on the cycle where `x_req && x_gnt`. The requester must hold its `x_req`, `x_we`, `x_addr` and `x_wdata` stable until granted.
- Grant selection is combinational from the requests and the `starve_cnt` register:
  - If `starve_cnt == STARVE_MAX` and `d_req` is high, debug is granted.
  - Otherwise, if `c_req` is high, core is granted.
  - Otherwise, if `d_req` is high, debug is granted.
  - Otherwise, no grant.
- At most one grant is high per cycle. Both grants are forced to 0 while `rst_n` is low.
- Memory mux:
  - `m_addr` and `m_wdata` come from the granted port.
  - When neither port is granted, `m_addr` and `m_wdata` come from the core port.
  - `m_we = (c_gnt & c_we) | (d_gnt & d_we)`.
- `starve_cnt` (8-bit register, reset to 0):
  - Clears when `d_req` is low or `d_gnt` is high.
  - Increments when `d_req` is high and `d_gnt` is low; saturates at `STARVE_MAX`.
- `starved` = (`starve_cnt == STARVE_MAX`) & `d_req`.
- Read response:
  - On a granted read, `m_rdata` is captured into that port's `x_rdata` register at the edge ending the grant cycle.
  - `x_rvalid` is high for exactly the following cycle.
  - `x_rdata` holds its value until the next read on that port.
- Writes produce no `rvalid`, and `x_rdata` is unchanged by writes.
- Back-to-back reads on the same port give consecutive `rvalid` pulses.
- Address is passed through unmodified; misaligned addresses are the requester's responsibility.

## Timing
- Reset (async, `rst_n` low): `c_rvalid`, `d_rvalid`, `starved` = 0; `c_rdata`, `d_rdata` = 0; `starve_cnt` = 0; `m_we` = 0.
- Latency:
  - Grant: 0 cycles.
  - Read data: 1 cycle after the grant cycle.
  - Write visible to a read: on the cycle after the write grant.
- Read then write to the same address on consecutive cycles: the read returns the old word.
- Write then read to the same address on consecutive cycles: the read returns the new word.
- Reset asserted mid-operation: a pending `rvalid` is dropped, and a memory write in the same cycle as reset does not occur.
- Sustained `c_req` with `d_req` high: debug is granted on exactly every (`STARVE_MAX`+1)-th cycle, i.e. `STARVE_MAX` core grants then 1 debug grant, repeating.
- `d_req` dropping while starved clears the counter. A new `d_req` restarts the count from 0.

## Test plan
- Reset: assert `rst_n`=0 with both ports requesting writes -> grants 0, `m_we` 0, all outputs 0. Release -> core is granted that cycle.
- Core write then read: write `0xDEADBEEF` to `0x40`, then read `0x40` next cycle -> `c_rvalid` pulses for 1 cycle 2 cycles after the write grant, `c_rdata` = `0xDEADBEEF`; `d_rvalid` stays 0.
- Contention, `STARVE_MAX`=4: `c_req` and `d_req` (read `0x0`) both held high -> `c_gnt` for cycles 0-3, `d_gnt` on cycle 4, `starved`=1 on cycle 4 only, `d_rvalid` on cycle 5.
- Debug-only traffic: debug writes `0x1` to `0x0`, then reads `0x0` -> `d_gnt` immediately each cycle, `d_rdata`=`0x1`, `starve_cnt` stays 0.
- Read-after-write hazard: core writes `0x55` to `0x8` in cycle N and debug reads `0x8` in cycle N+1 -> `d_rdata`=`0x55` in cycle N+2.
- Reset mid-read: read granted, then `rst_n` low before the edge -> no `rvalid`, `rdata` = 0 after reset.
